// File: rtl/snake_pkg.sv
// Shared types, grid constants and move arithmetic for the snake body and its occupancy map.
package snake_pkg;
  localparam int GRID_W      = 32;
  localparam int GRID_H      = 24;
  localparam int CELL        = 20;
  localparam int MAX_LEN     = 32;
  localparam int PTR_W       = $clog2(MAX_LEN);
  localparam int INIT_LEN    = 3;
  localparam int STEP_FRAMES = 8;
  localparam int OCC_N       = GRID_W * GRID_H;
  localparam int INIT_X      = 5;
  localparam int INIT_Y      = 12;

  typedef enum logic [1:0] {DIR_R = 2'd0, DIR_D = 2'd1, DIR_L = 2'd2, DIR_U = 2'd3} dir_t;
  typedef enum logic [1:0] {ST_WAIT, ST_CHECK, ST_COMMIT, ST_DEAD} state_t;

  // Signed so a step off the left/top edge shows up as -1; read back unsigned it is simply out of range.
  typedef logic signed [5:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  function automatic pos_t step(input pos_t p, input dir_t d);
    pos_t n;
    n = p;
    case (d)
      DIR_R:   n.x = p.x + 6'sd1;
      DIR_D:   n.y = p.y + 6'sd1;
      DIR_L:   n.x = p.x - 6'sd1;
      default: n.y = p.y - 6'sd1;
    endcase
    return n;
  endfunction

  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

  function automatic pos_t init_seg(input int i);
    pos_t p;
    p.x = coord_t'(INIT_X + i);
    p.y = coord_t'(INIT_Y);
    return p;
  endfunction
endpackage

// File: rtl/snake_occupancy.sv
// Grid occupancy bitmap: registered set/clear ports (set wins on the same cell), two combinational reads.
// Out-of-grid reads return 0, so negative or overflowing coordinates never alias onto a real cell.
module snake_occupancy
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  pos_t       set_pos,
  input  logic       clr_en,
  input  pos_t       clr_pos,
  input  pos_t       chk_pos,
  output logic       chk_occ,
  input  logic [5:0] pix_cx,
  input  logic [5:0] pix_cy,
  output logic       pix_occ
);
  localparam int IDX_W = $clog2(OCC_N);

  function automatic logic [IDX_W-1:0] cell_idx(input logic [5:0] x, input logic [5:0] y);
    return IDX_W'(int'(y) * GRID_W + int'(x));
  endfunction

  function automatic logic in_grid(input logic [5:0] x, input logic [5:0] y);
    return (x < 6'(GRID_W)) && (y < 6'(GRID_H));
  endfunction

  function automatic logic [OCC_N-1:0] init_map();
    logic [OCC_N-1:0] m;
    m = '0;
    for (int i = 0; i < INIT_LEN; i++) m[cell_idx(6'(INIT_X + i), 6'(INIT_Y))] = 1'b1;
    return m;
  endfunction

  localparam logic [OCC_N-1:0] OCC_INIT = init_map();

  logic [OCC_N-1:0] occ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ <= OCC_INIT;
    end else begin
      // Later assignment wins, so a set on the cell being cleared keeps it occupied.
      if (clr_en) occ[cell_idx(clr_pos.x, clr_pos.y)] <= 1'b0;
      if (set_en) occ[cell_idx(set_pos.x, set_pos.y)] <= 1'b1;
    end
  end

  assign chk_occ = in_grid(chk_pos.x, chk_pos.y) && occ[cell_idx(chk_pos.x, chk_pos.y)];
  assign pix_occ = in_grid(pix_cx, pix_cy) && occ[cell_idx(pix_cx, pix_cy)];
endmodule

// File: rtl/snake_body.sv
// Snake body: move FSM, segment ring buffer, collision detect, food handshake and per-pixel snake mask.
// One move per STEP_FRAMES frame ticks (CHECK then COMMIT); DEAD is left only through reset.
module snake_body
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [1:0] dir_in,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic [4:0] food_h,
  input  logic [4:0] food_v,
  output logic       new_food_flag,
  output logic       snake_loc,
  output logic       game_over,
  output logic [5:0] length
);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [7:0]       FCNT_LAST = 8'(STEP_FRAMES - 1);

  state_t           state, state_nxt;
  dir_t             dir, dir_req;
  pos_t             seg_buf [MAX_LEN];
  logic [PTR_W-1:0] head_ptr, tail_ptr;
  logic [7:0]       fcnt;
  logic             step_pend;
  pos_t             nxt_pos;
  logic             nxt_grow, nxt_eat;

  pos_t       head, tail, cand, food_pos;
  logic [5:0] cand_xu, cand_yu;
  logic       wall, eat, grow, self_hit, chk_occ;
  logic       tick_wrap, do_check, do_commit;
  logic [5:0] pix_cx, pix_cy;
  logic       pix_occ, pix_inside;

  assign head     = seg_buf[head_ptr];
  assign tail     = seg_buf[tail_ptr];
  assign cand     = step(head, dir_req);
  assign food_pos = {1'b0, food_h, 1'b0, food_v};
  assign cand_xu  = cand.x;
  assign cand_yu  = cand.y;

  assign wall     = (cand_xu >= 6'(GRID_W)) || (cand_yu >= 6'(GRID_H));
  assign eat      = (cand == food_pos);
  assign grow     = eat && (length < 6'(MAX_LEN));
  // Stepping onto the tail is legal unless the tail stays put because we grow.
  assign self_hit = chk_occ && !((cand == tail) && !grow);

  // Every STEP_FRAMES-th tick (counter already at its last value) requests a move.
  assign tick_wrap = frame_tick && (fcnt == FCNT_LAST);
  assign game_over = (state == ST_DEAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_WAIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_check  = 1'b0;
    do_commit = 1'b0;
    case (state)
      ST_WAIT:   if (tick_wrap || step_pend) state_nxt = ST_CHECK;
      ST_CHECK: begin
        do_check  = 1'b1;
        state_nxt = (wall || self_hit) ? ST_DEAD : ST_COMMIT;
      end
      ST_COMMIT: begin
        do_commit = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_DEAD:   state_nxt = ST_DEAD;
      default:   state_nxt = ST_WAIT;
    endcase
  end

  // A wrap seen outside WAIT is parked so no move is ever dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt      <= '0;
      step_pend <= 1'b0;
    end else if (state != ST_DEAD) begin
      if (frame_tick) fcnt <= tick_wrap ? '0 : fcnt + 8'd1;
      if (state == ST_WAIT) step_pend <= step_pend && tick_wrap;
      else                  step_pend <= step_pend || tick_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir     <= DIR_R;
      dir_req <= DIR_R;
    end else begin
      if (dir_t'(dir_in) != opposite(dir)) dir_req <= dir_t'(dir_in);
      if (do_check) dir <= dir_req;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LEN; i++) seg_buf[i] <= (i < INIT_LEN) ? init_seg(i) : pos_t'('0);
      head_ptr      <= PTR_W'(INIT_LEN - 1);
      tail_ptr      <= '0;
      length        <= 6'(INIT_LEN);
      nxt_pos       <= '0;
      nxt_grow      <= 1'b0;
      nxt_eat       <= 1'b0;
      new_food_flag <= 1'b0;
    end else begin
      if (do_check) begin
        nxt_pos  <= cand;
        nxt_grow <= grow;
        nxt_eat  <= eat;
      end
      if (do_commit) begin
        head_ptr                    <= head_ptr + PTR_ONE;
        seg_buf[head_ptr + PTR_ONE] <= nxt_pos;
        if (nxt_grow) length   <= length + 6'd1;
        else          tail_ptr <= tail_ptr + PTR_ONE;
      end
      if (do_commit && nxt_eat) new_food_flag <= 1'b1;
      else if (frame_tick)      new_food_flag <= 1'b0;
    end
  end

  snake_occupancy u_occ (
    .clk     (clk),
    .rst     (rst),
    .set_en  (do_commit),
    .set_pos (nxt_pos),
    .clr_en  (do_commit && !nxt_grow),
    .clr_pos (tail),
    .chk_pos (cand),
    .chk_occ (chk_occ),
    .pix_cx  (pix_cx),
    .pix_cy  (pix_cy),
    .pix_occ (pix_occ)
  );

  // Cell edges (multiples of CELL) are excluded, matching the food mask.
  assign pix_cx     = 6'(hpos / 10'(CELL));
  assign pix_cy     = 6'(vpos / 10'(CELL));
  assign pix_inside = (hpos > 10'(pix_cx) * 10'(CELL)) && (vpos > 10'(pix_cy) * 10'(CELL));
  assign snake_loc  = pix_occ && pix_inside;
endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: moves, growth, food flag timing, collisions, reset in COMMIT, pixel mask.
module tb_snake_body;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic [1:0] dir_in;
  logic [9:0] hpos, vpos;
  logic [4:0] food_h, food_v;
  logic       new_food_flag, snake_loc, game_over;
  logic [5:0] length;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  snake_body dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .dir_in        (dir_in),
    .hpos          (hpos),
    .vpos          (vpos),
    .food_h        (food_h),
    .food_v        (food_v),
    .new_food_flag (new_food_flag),
    .snake_loc     (snake_loc),
    .game_over     (game_over),
    .length        (length)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    frame_tick = 1'b0;
    dir_in     = 2'd0;
    food_h     = 5'd20;
    food_v     = 5'd20;
    hpos       = '0;
    vpos       = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Each tick is followed by idle cycles so a triggered CHECK/COMMIT has settled.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic check_cell(input string tag, input int x, input int y, input logic exp);
    @(negedge clk);
    hpos = 10'(x * CELL + CELL / 2);
    vpos = 10'(y * CELL + CELL / 2);
    #1;
    check(tag, 32'(snake_loc), 32'(exp));
  endtask

  task automatic move_into_death(input string tag);
    ticks(STEP_FRAMES - 1);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    #1 check({tag, "_in_check"}, 32'(game_over), 32'd0);
    @(negedge clk);
    #1 check({tag, "_dead"}, 32'(game_over), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests so far %0d", tests_run);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int errs;
    logic exp_loc;

    // Reset state and first move
    do_reset();
    check("rst_length", 32'(length), 32'd3);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_flag", 32'(new_food_flag), 32'd0);
    check_cell("rst_cell_5_12", 5, 12, 1'b1);
    check_cell("rst_cell_7_12", 7, 12, 1'b1);
    check_cell("rst_cell_8_12", 8, 12, 1'b0);
    ticks(STEP_FRAMES);
    check_cell("mv1_head_8_12", 8, 12, 1'b1);
    check_cell("mv1_tail_gone_5_12", 5, 12, 1'b0);
    check_cell("mv1_tail_6_12", 6, 12, 1'b1);
    check("mv1_length", 32'(length), 32'd3);
    check("mv1_game_over", 32'(game_over), 32'd0);
    check("mv1_flag", 32'(new_food_flag), 32'd0);

    // Eat at (9,12) on the second move
    food_h = 5'd9;
    food_v = 5'd12;
    ticks(STEP_FRAMES);
    check("eat_flag", 32'(new_food_flag), 32'd1);
    check("eat_length", 32'(length), 32'd4);
    check_cell("eat_tail_kept_6_12", 6, 12, 1'b1);
    check_cell("eat_head_9_12", 9, 12, 1'b1);
    food_h = 5'd20;
    food_v = 5'd20;
    @(negedge clk) frame_tick = 1'b1;
    #1 check("flag_during_tick", 32'(new_food_flag), 32'd1);
    @(negedge clk) frame_tick = 1'b0;
    #1 check("flag_after_tick", 32'(new_food_flag), 32'd0);

    // Reversal ignored, then U and L accepted
    dir_in = 2'd2;
    ticks(STEP_FRAMES - 1);
    check_cell("rev_head_10_12", 10, 12, 1'b1);
    check_cell("rev_tail_gone_6_12", 6, 12, 1'b0);
    check("rev_game_over", 32'(game_over), 32'd0);
    dir_in = 2'd3;
    ticks(STEP_FRAMES);
    check_cell("up_head_10_11", 10, 11, 1'b1);
    check_cell("up_not_11_12", 11, 12, 1'b0);
    dir_in = 2'd2;
    ticks(STEP_FRAMES);
    check_cell("left_head_9_11", 9, 11, 1'b1);
    check_cell("left_tail_gone_8_12", 8, 12, 1'b0);

    // 2x2 loop chasing the tail at length 4
    dir_in = 2'd1;
    ticks(STEP_FRAMES);
    check("chase1_game_over", 32'(game_over), 32'd0);
    check_cell("chase1_cell_9_12", 9, 12, 1'b1);
    dir_in = 2'd0;
    ticks(STEP_FRAMES);
    check("chase2_game_over", 32'(game_over), 32'd0);
    check_cell("chase2_cell_10_12", 10, 12, 1'b1);
    check_cell("chase2_cell_10_11", 10, 11, 1'b1);
    check("chase_length", 32'(length), 32'd4);

    // Grow to 5, then D, L, U into own body
    do_reset();
    food_h = 5'd8;
    food_v = 5'd12;
    ticks(STEP_FRAMES);
    food_h = 5'd9;
    ticks(STEP_FRAMES);
    check("grow5_length", 32'(length), 32'd5);
    food_h = 5'd20;
    food_v = 5'd20;
    dir_in = 2'd1;
    ticks(STEP_FRAMES);
    dir_in = 2'd2;
    ticks(STEP_FRAMES);
    dir_in = 2'd3;
    move_into_death("self");
    check("self_length", 32'(length), 32'd5);
    ticks(STEP_FRAMES);
    check("self_stays_dead", 32'(game_over), 32'd1);
    check_cell("self_frozen_tail_7_12", 7, 12, 1'b1);
    check_cell("self_frozen_head_8_13", 8, 13, 1'b1);

    // Right wall
    do_reset();
    ticks(24 * STEP_FRAMES);
    check_cell("wall_r_head_31_12", 31, 12, 1'b1);
    check("wall_r_alive", 32'(game_over), 32'd0);
    move_into_death("wall_r");
    check("wall_r_length", 32'(length), 32'd3);
    check_cell("wall_r_tail_29_12", 29, 12, 1'b1);

    // Top wall (row underflow)
    do_reset();
    dir_in = 2'd3;
    ticks(12 * STEP_FRAMES);
    check_cell("wall_u_head_7_0", 7, 0, 1'b1);
    move_into_death("wall_u");
    check("wall_u_length", 32'(length), 32'd3);
    check_cell("wall_u_frozen_7_1", 7, 1, 1'b1);

    // Reset asserted during COMMIT of an eating move
    do_reset();
    food_h = 5'd8;
    food_v = 5'd12;
    ticks(STEP_FRAMES - 1);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
    hpos = 10'(8 * CELL + 10);
    vpos = 10'(12 * CELL + 10);
    #1;
    check("rstc_loc_8_12", 32'(snake_loc), 32'd0);
    check("rstc_length", 32'(length), 32'd3);
    check("rstc_game_over", 32'(game_over), 32'd0);
    @(negedge clk);
    #1;
    check("rstc_hold_loc_8_12", 32'(snake_loc), 32'd0);
    check("rstc_hold_flag", 32'(new_food_flag), 32'd0);
    check("rstc_hold_length", 32'(length), 32'd3);
    food_h = 5'd20;
    food_v = 5'd20;
    rst    = 1'b1;
    check_cell("rstc_cell_5_12", 5, 12, 1'b1);
    ticks(STEP_FRAMES);
    check_cell("rstc_resume_8_12", 8, 12, 1'b1);
    check_cell("rstc_resume_5_12", 5, 12, 1'b0);
    check("rstc_resume_length", 32'(length), 32'd3);

    // Pixel mask over rows 11..13 across all hpos values
    do_reset();
    @(negedge clk);
    hpos = 10'd140;
    vpos = 10'd240;
    #1 check("pix_140_240", 32'(snake_loc), 32'd0);
    hpos = 10'd141;
    vpos = 10'd241;
    #1 check("pix_141_241", 32'(snake_loc), 32'd1);
    errs = 0;
    for (int v = 220; v <= 260; v++) begin
      for (int h = 0; h < 1024; h++) begin
        hpos = 10'(h);
        vpos = 10'(v);
        #1;
        exp_loc = (v / CELL == 12) && (h / CELL >= 5) && (h / CELL <= 7) &&
                  (h % CELL != 0) && (v % CELL != 0);
        if (snake_loc !== exp_loc) errs++;
      end
    end
    check("pix_sweep_errors", 32'(errs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
